ecc_secded_decoder: RTL

//  Receive-side SECDED Hamming(39,32) decoder: checks and corrects 39-bit codewords from the ECC encoder.

---
 rtl/ecc_secded_decoder_if.sv | 34 +++
 rtl/ecc_secded_decoder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ecc_secded_decoder_if.sv
//------------------------------------------------------------------------------
// Module      : ecc_secded_decoder_if
// Description : Codeword-in / payload-out valid/ready bundle for the SECDED decoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ecc_secded_decoder_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W+6:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sec;
  logic              out_ded;
  logic [5:0]        out_syn;

  // Environment side: produces codewords, consumes payloads
  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_sec, out_ded, out_syn
  );

  // Decoder side
  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_sec, out_ded, out_syn
  );
endinterface

`default_nettype wire

// File: rtl/ecc_secded_decoder.sv
//------------------------------------------------------------------------------
// Module      : ecc_secded_decoder
// Description : Two-stage SECDED Hamming(39,32) decoder; optional saturating
//               error counters when ECC_ERR_COUNT_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ecc_secded_decoder #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  wire              clock,
  input  wire              reset,
  ecc_secded_decoder_if.slave bus
`ifdef ECC_ERR_COUNT_EN
  ,
  input  wire              cnt_clear,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count
`endif
);

  localparam int             c_code_w  = DATA_W + 7;
  localparam int             c_syn_w   = 6;
  localparam logic [5:0]     c_max_pos = 6'd38;

  generate
    if (DATA_W != 32 || CNT_W < 1) begin : g_param_check
      $error("ecc_secded_decoder supports DATA_W=32 and CNT_W>=1 only");
    end
  endgenerate

  // Hamming position of data bit k: k-th non-power-of-two position from 3 up
  function automatic int data_pos(input int k);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int p = 3; p < c_code_w; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) pos = p;
        n++;
      end
    end
    return pos;
  endfunction

  logic               w_adv;
  logic [c_syn_w-1:0] w_syn;
  logic               w_par;
  logic [DATA_W-1:0]  w_raw;
  logic               w_fix;
  logic               w_sec;
  logic               w_ded;
  logic [DATA_W-1:0]  w_data;

  logic               r_s1_valid;
  logic [c_syn_w-1:0] r_s1_syn;
  logic               r_s1_par;
  logic [DATA_W-1:0]  r_s1_data;

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_sec;
  logic               r_out_ded;
  logic [c_syn_w-1:0] r_out_syn;

  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  always_comb begin
    w_syn = '0;
    for (int i = 1; i < c_code_w; i++) begin
      if (bus.in_code[i]) w_syn = w_syn ^ c_syn_w'(i);
    end
  end

  assign w_par = ^bus.in_code;

  // Only data positions are carried into S1; check bits live on in the syndrome
  generate
    for (genvar k = 0; k < DATA_W; k++) begin : g_extract
      assign w_raw[k]  = bus.in_code[data_pos(k)];
      assign w_data[k] = r_s1_data[k] ^ (w_fix && (r_s1_syn == c_syn_w'(data_pos(k))));
    end
  endgenerate

  assign w_fix = r_s1_par && (r_s1_syn != '0) && (r_s1_syn <= c_max_pos);
  assign w_sec = r_s1_par && (r_s1_syn <= c_max_pos);
  assign w_ded = (r_s1_par && (r_s1_syn > c_max_pos)) || (!r_s1_par && (r_s1_syn != '0));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_syn    <= '0;
      r_s1_par    <= 1'b0;
      r_s1_data   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sec   <= 1'b0;
      r_out_ded   <= 1'b0;
      r_out_syn   <= '0;
    end else if (w_adv) begin
      r_s1_valid  <= bus.in_valid;
      r_s1_syn    <= w_syn;
      r_s1_par    <= w_par;
      r_s1_data   <= w_raw;
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_data;
        r_out_sec  <= w_sec;
        r_out_ded  <= w_ded;
        r_out_syn  <= r_s1_syn;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sec   = r_out_sec;
  assign bus.out_ded   = r_out_ded;
  assign bus.out_syn   = r_out_syn;

`ifdef ECC_ERR_COUNT_EN
  logic [CNT_W-1:0] r_sec_count;
  logic [CNT_W-1:0] r_ded_count;
  logic             w_out_hs;

  assign w_out_hs = r_out_valid && bus.out_ready;

  // Clear has priority over a same-cycle increment
  always_ff @(posedge clock) begin
    if (reset || cnt_clear) begin
      r_sec_count <= '0;
      r_ded_count <= '0;
    end else if (w_out_hs) begin
      if (r_out_sec && (r_sec_count != '1)) r_sec_count <= r_sec_count + CNT_W'(1);
      if (r_out_ded && (r_ded_count != '1)) r_ded_count <= r_ded_count + CNT_W'(1);
    end
  end

  assign sec_count = r_sec_count;
  assign ded_count = r_ded_count;
`else
  // Counter-free build: decode path above is the whole design
`endif

endmodule

`default_nettype wire
